// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Moore FSM controller for the 16-bit datapath. It holds the program counter
// (PC) and the instruction register (IR). It fetches from a synchronous
// instruction ROM with one cycle of latency, decodes the 4-bit opcode in
// IR[15:12], and sequences NOOP, STORE, LOAD, ADD, SUB and HALT. The datapath
// control outputs connect one-to-one to the datapath ports.
//
// Instruction timing: FETCH, DECODE, execute (3 cycles). LOAD uses two execute
// cycles (LOAD_A, LOAD_B), so it takes 4 cycles. HALT is held until reset.
//
// Optional feature (compile-time macro CU_JUMP_EN):
//   defined   : opcode 6 is JUMP. PC <= IR[PC_W-1:0], zero-extended when
//               PC_W > 12. No datapath writes. Fetching resumes at the target.
//   undefined : opcode 6 decodes as NOOP and the JUMP state is unreachable.
//
// Parameters
//   PC_W       PC / instruction address width (program space 2**PC_W words)
//
// Ports
//   clk        system clock; all state updates happen on posedge
//   reset      synchronous, active-high; forces INIT, PC=0, IR=0
//   I_data     instruction ROM q, valid one cycle after I_addr is sampled
//   I_addr     instruction ROM address (always equals PC)
//   D_addr     data memory address
//   D_wr       data memory write enable (forced low while reset=1)
//   RF_sel     register write-data select: 0 = ALU result, 1 = data memory q
//   RF_W_en    register file write enable (forced low while reset=1)
//   WriteAddr  register file write address, IR[3:0]
//   rdAddrA    register file read address A, IR[11:8]
//   rdAddrB    register file read address B, IR[7:4]
//   ALU_s0     ALU function: 0 = pass-zero, 1 = A+B, 2 = A-B
//   PC_out     monitor: current PC
//   IR_out     monitor: current IR
//   state_out  monitor: current state encoding
//   halted     high while in HALT
// -----------------------------------------------------------------------------
module control_unit #(
    parameter int unsigned PC_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     I_data,
    output logic [PC_W-1:0] I_addr,
    output logic [7:0]      D_addr,
    output logic            D_wr,
    output logic            RF_sel,
    output logic            RF_W_en,
    output logic [3:0]      WriteAddr,
    output logic [3:0]      rdAddrA,
    output logic [3:0]      rdAddrB,
    output logic [2:0]      ALU_s0,
    output logic [PC_W-1:0] PC_out,
    output logic [15:0]     IR_out,
    output logic [3:0]      state_out,
    output logic            halted
);

    // State encodings are visible on state_out and must stay fixed.
    localparam logic [3:0] StInit   = 4'd0;
    localparam logic [3:0] StFetch  = 4'd1;
    localparam logic [3:0] StDecode = 4'd2;
    localparam logic [3:0] StLoadA  = 4'd3;
    localparam logic [3:0] StLoadB  = 4'd4;
    localparam logic [3:0] StStore  = 4'd5;
    localparam logic [3:0] StAdd    = 4'd6;
    localparam logic [3:0] StSub    = 4'd7;
    localparam logic [3:0] StNoop   = 4'd8;
    localparam logic [3:0] StHalt   = 4'd9;
    localparam logic [3:0] StJump   = 4'd10;

    // Opcodes, taken from IR[15:12].
    localparam logic [3:0] OpNoop  = 4'd0;
    localparam logic [3:0] OpStore = 4'd1;
    localparam logic [3:0] OpLoad  = 4'd2;
    localparam logic [3:0] OpAdd   = 4'd3;
    localparam logic [3:0] OpSub   = 4'd4;
    localparam logic [3:0] OpHalt  = 4'd5;
`ifdef CU_JUMP_EN
    localparam logic [3:0] OpJump  = 4'd6;
`endif

    // ALU function codes.
    localparam logic [2:0] AluZero = 3'd0;
    localparam logic [2:0] AluAdd  = 3'd1;
    localparam logic [2:0] AluSub  = 3'd2;

    logic [3:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [3:0]      opcode;

    // Raw enables before reset gating.
    logic            d_wr_raw;
    logic            rf_we_raw;

    assign opcode = ir_q[15:12];

`ifdef CU_JUMP_EN
    // The jump target is the low bits of IR. It is zero-extended when PC_W
    // is wider than the 12-bit operand field.
    logic [PC_W-1:0] jump_tgt;

    always_comb begin
        jump_tgt = '0;
        for (int i = 0; i < int'(PC_W); i++) begin
            if (i < 12) begin
                jump_tgt[i] = ir_q[i];
            end
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state, PC and IR
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;

        case (state_q)
            StInit: begin
                pc_d    = '0;
                state_d = StFetch;
            end

            StFetch: begin
                // The ROM already holds the word for the current PC.
                // The increment wraps naturally at 2**PC_W.
                ir_d    = I_data;
                pc_d    = pc_q + PC_W'(1);
                state_d = StDecode;
            end

            StDecode: begin
                case (opcode)
                    OpNoop:  state_d = StNoop;
                    OpStore: state_d = StStore;
                    OpLoad:  state_d = StLoadA;
                    OpAdd:   state_d = StAdd;
                    OpSub:   state_d = StSub;
                    OpHalt:  state_d = StHalt;
`ifdef CU_JUMP_EN
                    OpJump: begin
                        // Load PC on entry to JUMP, so PC already holds the
                        // target while in JUMP. The ROM then samples the
                        // target on the JUMP->FETCH edge, and I_data is
                        // valid in the following FETCH.
                        pc_d    = jump_tgt;
                        state_d = StJump;
                    end
`endif
                    default: state_d = StNoop;  // illegal opcodes act as NOOP
                endcase
            end

            StLoadA: state_d = StLoadB;

            StLoadB, StStore, StAdd, StSub, StNoop, StJump: state_d = StFetch;

            StHalt: state_d = StHalt;

            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StInit;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // -------------------------------------------------------------------------
    // Moore output decode from state and IR
    // -------------------------------------------------------------------------
    always_comb begin
        D_addr    = 8'h00;
        d_wr_raw  = 1'b0;
        RF_sel    = 1'b0;
        rf_we_raw = 1'b0;
        ALU_s0    = AluZero;

        case (state_q)
            StLoadA: begin
                // First LOAD cycle: the address is presented so that the
                // data memory output can settle. Nothing is written yet.
                D_addr = ir_q[11:4];
                RF_sel = 1'b1;
            end
            StLoadB: begin
                D_addr    = ir_q[11:4];
                RF_sel    = 1'b1;
                rf_we_raw = 1'b1;
            end
            StStore: begin
                D_addr   = ir_q[7:0];
                d_wr_raw = 1'b1;
            end
            StAdd: begin
                ALU_s0    = AluAdd;
                rf_we_raw = 1'b1;
            end
            StSub: begin
                ALU_s0    = AluSub;
                rf_we_raw = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Reset gates the write enables combinationally. An instruction that is
    // interrupted by reset therefore never commits on the reset edge.
    assign D_wr    = d_wr_raw & ~reset;
    assign RF_W_en = rf_we_raw & ~reset;

    // Register addresses are fixed IR fields. They only matter when an
    // enable is set.
    assign WriteAddr = ir_q[3:0];
    assign rdAddrA   = ir_q[11:8];
    assign rdAddrB   = ir_q[7:4];

    assign I_addr    = pc_q;
    assign PC_out    = pc_q;
    assign IR_out    = ir_q;
    assign state_out = state_q;
    assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit. A reference model walks each program
// instruction by instruction. For every cycle in which the controller should
// drive datapath activity, the model queues the expected outputs and the
// expected cycle number. A negedge monitor pops the queue and compares.
module tb_control_unit;

    localparam int PC_W  = 7;
    localparam int ROM_N = 1 << PC_W;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [15:0]     I_data;
    logic [PC_W-1:0] I_addr;
    logic [7:0]      D_addr;
    logic            D_wr, RF_sel, RF_W_en;
    logic [3:0]      WriteAddr, rdAddrA, rdAddrB;
    logic [2:0]      ALU_s0;
    logic [PC_W-1:0] PC_out;
    logic [15:0]     IR_out;
    logic [3:0]      state_out;
    logic            halted;

    control_unit #(.PC_W(PC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .I_data    (I_data),
        .I_addr    (I_addr),
        .D_addr    (D_addr),
        .D_wr      (D_wr),
        .RF_sel    (RF_sel),
        .RF_W_en   (RF_W_en),
        .WriteAddr (WriteAddr),
        .rdAddrA   (rdAddrA),
        .rdAddrB   (rdAddrB),
        .ALU_s0    (ALU_s0),
        .PC_out    (PC_out),
        .IR_out    (IR_out),
        .state_out (state_out),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction ROM with one cycle of latency.
    logic [15:0] rom [ROM_N];
    always @(posedge clk) I_data <= rom[I_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] daddr;
        bit         wr, sel, we;
        logic [3:0] wa, ra, rb;
        logic [2:0] alu;
        int         pc;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: any visible datapath activity is one event.
    always @(negedge clk) begin
        if (mon_en && (D_wr || RF_W_en || RF_sel || ALU_s0 != 3'd0 || D_addr != 8'd0)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_event: cycle %0d D_wr=%0b RF_W_en=%0b RF_sel=%0b ALU=%0d D_addr=0x%0h, expected none",
                         cyc, D_wr, RF_W_en, RF_sel, ALU_s0, D_addr);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("ev_cycle", cyc, e.cyc);
                chk("D_addr", D_addr, e.daddr);
                chk("D_wr", D_wr, e.wr);
                chk("RF_sel", RF_sel, e.sel);
                chk("RF_W_en", RF_W_en, e.we);
                chk("ALU_s0", ALU_s0, e.alu);
                chk("WriteAddr", WriteAddr, e.wa);
                chk("rdAddrA", rdAddrA, e.ra);
                chk("rdAddrB", rdAddrB, e.rb);
                chk("PC_out", PC_out, e.pc);
            end
        end
    end

    // Reference model. The first FETCH happens one cycle after reset is
    // released. Execute starts two cycles after FETCH. Each instruction takes
    // 3 cycles, and LOAD takes 4.
    task automatic model(input int rel, input int k_max, output bit halts,
                         output int t_end, output int hpc);
        int pc = 0;
        int t  = rel + 1;
        halts = 1'b0;
        hpc   = 0;
        for (int n = 0; n < k_max; n++) begin
            logic [15:0] ir;
            ev_t e;
            ir = rom[pc];
            pc = (pc + 1) % ROM_N;
            e.cyc = t + 2; e.wa = ir[3:0]; e.ra = ir[11:8]; e.rb = ir[7:4]; e.pc = pc;
            e.daddr = 8'h00; e.wr = 0; e.sel = 0; e.we = 0; e.alu = 3'd0;
            case (ir[15:12])
                4'd1: begin e.daddr = ir[7:0]; e.wr = 1; exp_q.push_back(e); t += 3; end
                4'd2: begin
                    e.daddr = ir[11:4]; e.sel = 1; exp_q.push_back(e);
                    e.cyc = t + 3; e.we = 1; exp_q.push_back(e);
                    t += 4;
                end
                4'd3: begin e.alu = 3'd1; e.we = 1; exp_q.push_back(e); t += 3; end
                4'd4: begin e.alu = 3'd2; e.we = 1; exp_q.push_back(e); t += 3; end
                4'd5: begin halts = 1; hpc = pc; t_end = t + 2; return; end
`ifdef CU_JUMP_EN
                4'd6: begin pc = int'(ir[PC_W-1:0]); t += 3; end
`endif
                default: t += 3;
            endcase
        end
        t_end = t;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_state", state_out, 0);
        chk("rst_pc", PC_out, 0);
        chk("rst_ir", IR_out, 0);
        chk("rst_en", {D_wr, RF_W_en, halted}, 0);
        @(negedge clk);
    endtask

    task automatic run_prog(input int k_max, input int extra);
        int rel, t_end, hpc;
        bit halts;
        do_reset();
        reset  = 1'b0;
        rel    = cyc;
        mon_en = 1'b1;
        model(rel, k_max, halts, t_end, hpc);
        chk("st_init", state_out, 0);
        @(negedge clk);
        chk("st_fetch", state_out, 1);
        chk("pc_fetch", PC_out, 0);
        @(negedge clk);
        chk("st_decode", state_out, 2);
        chk("pc_decode", PC_out, 1);
        while (cyc < t_end + extra) @(negedge clk);
        mon_en = 1'b0;
        if (halts) begin
            chk("halted", halted, 1);
            chk("halt_state", state_out, 9);
            chk("halt_pc", PC_out, hpc);
            chk("halt_en", {D_wr, RF_W_en}, 0);
        end
        chk("events_left", exp_q.size(), 0);
    endtask

    // Assert reset while a write-enable cycle is active. The enable must drop
    // at once, and the next state must be INIT.
    task automatic abort_test(input logic [15:0] w, input int off, input int st, input bit is_store);
        int rel;
        foreach (rom[i]) rom[i] = 16'h0000;
        rom[0] = w;
        do_reset();
        reset = 1'b0;
        rel   = cyc;
        while (cyc < rel + off) @(negedge clk);
        chk("abort_state_before", state_out, st);
        chk("abort_en_before", is_store ? D_wr : RF_W_en, 1);
        reset = 1'b1;
        #1;
        chk("abort_en_gated", is_store ? D_wr : RF_W_en, 0);
        @(negedge clk);
        chk("abort_state_after", state_out, 0);
        chk("abort_pc_after", PC_out, 0);
    endtask

    function automatic logic [15:0] rand_instr(input int addr, input int last, input bit jumps);
        logic [15:0] w;
        logic [3:0]  op;
        op = 4'($urandom_range(0, 15));
        while (op == 4'd5 || (op == 4'd6 && !jumps)) op = 4'($urandom_range(0, 15));
        w = 16'($urandom);
        w[15:12] = op;
        // Jumps only go forward, so every program still reaches its HALT.
        if (op == 4'd6) w[PC_W-1:0] = PC_W'($urandom_range(addr + 1, last));
        return w;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (rom[i]) rom[i] = 16'h0000;

        // LOAD, STORE, ADD, SUB, HALT
        rom[0] = 16'h2011; rom[1] = 16'h116A; rom[2] = 16'h3123;
        rom[3] = 16'h4021; rom[4] = 16'h5000;
        run_prog(50, 10);

        // Opcode 6: a jump when enabled, otherwise a NOOP
        foreach (rom[i]) rom[i] = 16'h0000;
        rom[0] = 16'h6007; rom[1] = 16'h3456; rom[2] = 16'h5000;
        rom[7] = 16'h3123; rom[8] = 16'h5000;
        run_prog(50, 10);

        abort_test(16'h2011, 4, 4, 1'b0);
        abort_test(16'h116A, 3, 5, 1'b1);

        // Random halting programs
        repeat (6) begin
            int n;
            n = $urandom_range(8, 30);
            foreach (rom[i]) rom[i] = 16'($urandom);
            for (int a = 0; a < n; a++) rom[a] = rand_instr(a, n, 1'b1);
            rom[n] = 16'h5000 | 16'($urandom_range(0, 4095));
            run_prog(200, 10);
        end

        // Run through the whole program space, so PC wraps from 127 to 0
        foreach (rom[i]) rom[i] = rand_instr(i, i + 1, 1'b0);
        run_prog(135, 0);

        do_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
